// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that lets one of three drawing engines (clear, score bar,
// character) own the VGA adapter pixel port at a time, with a grant-length timeout.
module vga_draw_arbiter #(
  parameter int unsigned TIMEOUT = 40000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  req_done,
  input  logic [2:0]  req_plot,
  input  logic [26:0] req_x,
  input  logic [26:0] req_y,
  input  logic [17:0] req_colour,
  output logic [2:0]  gnt,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic [5:0]  colour,
  output logic        writeEn,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned XY_W  = 9;
  localparam int unsigned COL_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XY_W-1:0]    x_q, x_d;
  logic [XY_W-1:0]    y_q, y_d;
  logic [COL_W-1:0]   colour_q, colour_d;
  logic               write_en_q, write_en_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;

  logic [1:0]         win;
  logic               sel_req, sel_done, sel_plot, at_limit;
  logic [XY_W-1:0]    sel_x, sel_y;
  logic [COL_W-1:0]   sel_colour;

  // Round-robin pick: search begins just after the last winner.
  always_comb begin
    win = 2'd0;
    unique case (last_q)
      2'd0: begin
        if      (req[1]) win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if      (req[2]) win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if      (req[0]) win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

  // While granted, last_q holds the owner, so it selects the owner's fields.
  always_comb begin
    sel_req    = 1'b0;
    sel_done   = 1'b0;
    sel_plot   = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    unique case (last_q)
      2'd0: begin
        sel_req = req[0]; sel_done = req_done[0]; sel_plot = req_plot[0];
        sel_x = req_x[8:0]; sel_y = req_y[8:0]; sel_colour = req_colour[5:0];
      end
      2'd1: begin
        sel_req = req[1]; sel_done = req_done[1]; sel_plot = req_plot[1];
        sel_x = req_x[17:9]; sel_y = req_y[17:9]; sel_colour = req_colour[11:6];
      end
      default: begin
        sel_req = req[2]; sel_done = req_done[2]; sel_plot = req_plot[2];
        sel_x = req_x[26:18]; sel_y = req_y[26:18]; sel_colour = req_colour[17:12];
      end
    endcase
  end

  assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    write_en_d    = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = 3'b000;
        if (|req) begin
          state_d = ST_GRANT;
          gnt_d   = 3'b001 << win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        cnt_d      = cnt_q + CNT_W'(1);
        write_en_d = sel_plot;
        if (sel_plot) begin
          x_d      = sel_x;
          y_d      = sel_y;
          colour_d = sel_colour;
        end
        // Done wins over a coincident timeout, suppressing the error pulse.
        if (sel_done || !sel_req || at_limit) begin
          state_d       = ST_RELEASE;
          gnt_d         = 3'b000;
          timeout_err_d = at_limit && !sel_done;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 3'b000;
      last_q        <= 2'd2;
      cnt_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
      write_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      write_en_q    <= write_en_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign gnt         = gnt_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign writeEn     = write_en_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: reset, round-robin order, pixel forwarding,
// timeout release, done/timeout precedence and reset during a grant.
module tb_vga_draw_arbiter;

  logic        clk;
  logic        resetn;
  logic [2:0]  req, req_done, req_plot;
  logic [26:0] req_x, req_y;
  logic [17:0] req_colour;
  logic [2:0]  gnt;
  logic [8:0]  x, y;
  logic [5:0]  colour;
  logic        writeEn, busy, timeout_err;

  int total;
  int bad;

  vga_draw_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_done    (req_done),
    .req_plot    (req_plot),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_colour  (req_colour),
    .gnt         (gnt),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .writeEn     (writeEn),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and new inputs may be driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = '0; req_done = '0; req_plot = '0;
    req_x = '0; req_y = '0; req_colour = '0;
    tick(); tick();
    total++;
    if (gnt !== 3'b000 || writeEn !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: gnt=%b we=%b busy=%b terr=%b want 000 0 0 0", gnt, writeEn, busy, timeout_err);
    end
    total++;
    if (x !== 9'd0 || y !== 9'd0 || colour !== 6'd0) begin
      bad++;
      $display("FAIL reset_pixel: x=%0d y=%0d c=%0d want 0 0 0", x, y, colour);
    end
  endtask

  // Wait for grant of idx, stream 4 plots, then pulse done.
  task automatic serve(input int idx, input int exp_wait);
    int waited;
    logic [8:0] ex, ey;
    logic [5:0] ec;
    waited = 0;
    ex = '0; ey = '0; ec = '0;
    while (gnt === 3'b000 && waited < 10) begin
      tick();
      waited++;
    end
    total++;
    if (gnt !== (3'b001 << idx)) begin
      bad++;
      $display("FAIL rr_order: gnt=%b want %b", gnt, 3'b001 << idx);
    end
    total++;
    if (waited != exp_wait) begin
      bad++;
      $display("FAIL rr_gap: waited=%0d cycles want %0d", waited, exp_wait);
    end
    for (int k = 0; k < 4; k++) begin
      ex = 9'(idx * 20 + k + 1);
      ey = 9'(100 + idx + k);
      ec = 6'(idx * 8 + k);
      req_plot = 3'b001 << idx;
      req_x[9*idx +: 9] = ex;
      req_y[9*idx +: 9] = ey;
      req_colour[6*idx +: 6] = ec;
      tick();
      total++;
      if (writeEn !== 1'b1 || x !== ex || y !== ey || colour !== ec || $countones(gnt) > 1) begin
        bad++;
        $display("FAIL rr_plot: we=%b x=%0d y=%0d c=%0d gnt=%b want 1 %0d %0d %0d", writeEn, x, y, colour, gnt, ex, ey, ec);
      end
    end
    req_plot = '0;
    req_done = 3'b001 << idx;
    tick();
    req_done = '0;
    total++;
    if (gnt !== 3'b000 || writeEn !== 1'b0 || timeout_err !== 1'b0 || x !== ex || busy !== 1'b1) begin
      bad++;
      $display("FAIL rr_done: gnt=%b we=%b terr=%b x=%0d busy=%b want 000 0 0 %0d 1", gnt, writeEn, timeout_err, x, busy, ex);
    end
  endtask

  task automatic test_round_robin();
    req = 3'b111;
    resetn = 1'b1;
    serve(0, 1);
    serve(1, 2);
    serve(2, 2);
    serve(0, 2);
    req = '0;
    tick(); tick();
  endtask

  task automatic test_plot_select();
    req = 3'b010;
    tick();
    total++;
    if (gnt !== 3'b010) begin
      bad++;
      $display("FAIL sel_gnt: gnt=%b want 010", gnt);
    end
    req_plot = 3'b110;
    req_x[17:9] = 9'd10;  req_y[17:9] = 9'd44;  req_colour[11:6] = 6'b001001;
    req_x[26:18] = 9'd300; req_y[26:18] = 9'd200; req_colour[17:12] = 6'b111111;
    tick();
    total++;
    if (writeEn !== 1'b1 || x !== 9'd10 || y !== 9'd44 || colour !== 6'b001001) begin
      bad++;
      $display("FAIL sel_write: we=%b x=%0d y=%0d c=%b want 1 10 44 001001", writeEn, x, y, colour);
    end
    req_plot = 3'b100;
    tick();
    total++;
    if (writeEn !== 1'b0 || x !== 9'd10 || y !== 9'd44 || colour !== 6'b001001) begin
      bad++;
      $display("FAIL sel_ignore: we=%b x=%0d y=%0d c=%b want 0 10 44 001001", writeEn, x, y, colour);
    end
    req_plot = '0;
    req_done = 3'b100;
    tick();
    req_done = '0;
    total++;
    if (gnt !== 3'b010) begin
      bad++;
      $display("FAIL sel_foreign_done: gnt=%b want 010", gnt);
    end
    req = '0;
    tick();
    total++;
    if (gnt !== 3'b000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sel_release: gnt=%b busy=%b want 000 1", gnt, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL sel_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int held;
    req = 3'b011;
    tick();
    total++;
    if (gnt !== 3'b001) begin
      bad++;
      $display("FAIL to_gnt: gnt=%b want 001", gnt);
    end
    held = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt !== 3'b001) break;
      held++;
      total++;
      if (timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL to_early_err: terr=%b want 0 at held=%0d", timeout_err, held);
      end
    end
    total++;
    if (held != 8 || gnt !== 3'b000 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_release: held=%0d gnt=%b terr=%b want 8 000 1", held, gnt, timeout_err);
    end
    tick();
    total++;
    if (gnt !== 3'b000 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_pulse: gnt=%b terr=%b want 000 0", gnt, timeout_err);
    end
    tick();
    total++;
    if (gnt !== 3'b010) begin
      bad++;
      $display("FAIL to_next: gnt=%b want 010", gnt);
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_done_on_timeout();
    req = 3'b001;
    tick();
    total++;
    if (gnt !== 3'b001) begin
      bad++;
      $display("FAIL dt_gnt: gnt=%b want 001", gnt);
    end
    repeat (7) tick();
    req_done = 3'b001;
    req_plot = 3'b001;
    req_x[8:0] = 9'd77; req_y[8:0] = 9'd33; req_colour[5:0] = 6'd21;
    tick();
    total++;
    if (gnt !== 3'b000 || timeout_err !== 1'b0 || writeEn !== 1'b1 || x !== 9'd77 || y !== 9'd33 || colour !== 6'd21) begin
      bad++;
      $display("FAIL dt_exit: gnt=%b terr=%b we=%b x=%0d y=%0d c=%0d want 000 0 1 77 33 21", gnt, timeout_err, writeEn, x, y, colour);
    end
    req_done = '0; req_plot = '0; req = '0;
    tick();
    total++;
    if (timeout_err !== 1'b0 || writeEn !== 1'b0) begin
      bad++;
      $display("FAIL dt_after: terr=%b we=%b want 0 0", timeout_err, writeEn);
    end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 3'b001;
    tick();
    total++;
    if (gnt !== 3'b001) begin
      bad++;
      $display("FAIL rm_gnt: gnt=%b want 001", gnt);
    end
    req_plot = 3'b001;
    req_x[8:0] = 9'd5; req_y[8:0] = 9'd6; req_colour[5:0] = 6'd7;
    tick();
    total++;
    if (writeEn !== 1'b1 || x !== 9'd5) begin
      bad++;
      $display("FAIL rm_stream: we=%b x=%0d want 1 5", writeEn, x);
    end
    resetn = 1'b0;
    tick();
    total++;
    if (writeEn !== 1'b0 || gnt !== 3'b000 || x !== 9'd0 || y !== 9'd0 || colour !== 6'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rm_abort: we=%b gnt=%b x=%0d y=%0d c=%0d busy=%b want 0 000 0 0 0 0", writeEn, gnt, x, y, colour, busy);
    end
    resetn = 1'b1;
    req_plot = '0;
    req = 3'b110;
    tick();
    total++;
    if (gnt !== 3'b010) begin
      bad++;
      $display("FAIL rm_rearb: gnt=%b want 010", gnt);
    end
    req = '0;
    tick(); tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_round_robin();
    test_plot_select();
    test_timeout();
    test_done_on_timeout();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
